// File: rtl/store_pkg.sv
// Shared types and constants for the store buffer.
// Entry widths fix the address and data width at 32 bits.
package store_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } store_state_e;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [3:0]       mask;
  } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Lane alignment of one store: low/high word data and the
// 8-lane byte mask spanning both words.
module store_align (
  input  logic [1:0]  off,
  input  logic [3:0]  mask,
  input  logic [31:0] data,
  output logic [31:0] lo_data,
  output logic [31:0] hi_data,
  output logic [7:0]  m8
);

  logic [63:0] wide;

  always_comb begin
    wide    = {32'b0, data} << {off, 3'b000};
    lo_data = wide[31:0];
    hi_data = wide[63:32];
    m8      = {4'b0, mask} << off;
  end

endmodule

// File: rtl/store_buffer.sv
// Store queue draining into a single-ported data memory,
// splitting word-crossing stores and flagging load hazards.
module store_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [3:0]    st_mask,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_data,
  output logic [3:0]    wr_en,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t  fifo_q [DEPTH];
  store_entry_t  fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  store_state_e  state_q, state_d;

  logic          push, pop, full;
  logic [DW-1:0] lo_data [DEPTH];
  logic [DW-1:0] hi_data [DEPTH];
  logic [7:0]    m8      [DEPTH];
  logic [DEPTH-1:0] hit;

  logic [AW-3:0] ld_w;
  logic [AW-3:0] h_w;
  logic          h_spill;
  logic          more;
  logic          unused_ok;

  assign ld_w      = ld_addr[AW-1:2];
  assign unused_ok = &{1'b0, ld_addr[1:0]};

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] rel;
    logic [AW-3:0] ent_w;
    logic [AW-3:0] nxt_w;

    store_align u_align (
      .off     (fifo_q[g].addr[1:0]),
      .mask    (fifo_q[g].mask),
      .data    (fifo_q[g].data),
      .lo_data (lo_data[g]),
      .hi_data (hi_data[g]),
      .m8      (m8[g])
    );

    // Slot distance from the head decides whether it is live.
    assign rel   = PW'(g) - rd_ptr_q;
    assign ent_w = fifo_q[g].addr[AW-1:2];
    assign nxt_w = ent_w + (AW-2)'(1);
    assign hit[g] = ({1'b0, rel} < count_q) &&
                    ((ld_w == ent_w) ||
                     ((|m8[g][7:4]) && (ld_w == nxt_w)));
  end

  assign ld_hazard = |hit;
  assign h_w       = fifo_q[rd_ptr_q].addr[AW-1:2];
  assign h_spill   = |m8[rd_ptr_q][7:4];

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    st_ready = !full;
    empty    = (count_q == '0);
    push     = st_valid && !full && (st_mask != 4'b0);
    more     = (count_q > CW'(1)) || push;
    pop      = 1'b0;
    state_d  = state_q;
    mem_req  = 1'b0;
    d_addr   = '0;
    d_data   = '0;
    wr_en    = 4'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty || push) state_d = LO;
      end
      LO: begin
        mem_req = 1'b1;
        d_addr  = {h_w, 2'b00};
        d_data  = lo_data[rd_ptr_q];
        wr_en   = m8[rd_ptr_q][3:0];
        if (mem_ack) begin
          if (h_spill) begin
            state_d = HI;
          end else begin
            pop     = 1'b1;
            state_d = more ? LO : IDLE;
          end
        end
      end
      HI: begin
        mem_req = 1'b1;
        d_addr  = {h_w + (AW-2)'(1), 2'b00};
        d_data  = hi_data[rd_ptr_q];
        wr_en   = m8[rd_ptr_q][7:4];
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = more ? LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: st_addr, data: st_data, mask: st_mask};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a
// byte-level model of pending stores and expected writes.
module tb_store_buffer;
  import store_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] d_addr;
  logic [31:0] d_data;
  logic [3:0]  wr_en;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_mask   (st_mask),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .d_addr    (d_addr),
    .d_data    (d_data),
    .wr_en     (wr_en),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    bit          last;
  } tx_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  tx_t exp_q[$];
  st_t st_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard(logic [31:0] la);
    logic [31:0] b;
    foreach (st_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = st_q[i].a + 32'(k);
        if (st_q[i].m[k] && (b[31:2] == la[31:2])) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Writes derive from the byte addresses each store touches.
  task automatic add_store(logic [31:0] a, logic [31:0] d,
                           logic [3:0] m);
    logic [63:0] v;
    logic [31:0] b;
    logic [31:0] base;
    logic [3:0]  lw;
    logic [3:0]  hw;
    v    = {32'b0, d} << (8 * a[1:0]);
    base = {a[31:2], 2'b00};
    lw   = 4'b0;
    hw   = 4'b0;
    for (int k = 0; k < 4; k++) begin
      b = a + 32'(k);
      if (m[k]) begin
        if (b[31:2] == a[31:2]) lw[b[1:0]] = 1'b1;
        else hw[b[1:0]] = 1'b1;
      end
    end
    st_q.push_back('{a: a, d: d, m: m});
    exp_q.push_back('{a: base, d: v[31:0], w: lw, last: (hw == 4'b0)});
    if (hw != 4'b0)
      exp_q.push_back('{a: base + 32'd4, d: v[63:32], w: hw, last: 1'b1});
  endtask

  task automatic tick();
    bit  acc;
    bit  ack;
    tx_t t;
    @(negedge clk);
    chk("mem_req", mem_req, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("d_addr", d_addr, exp_q[0].a);
      chk("d_data", d_data, exp_q[0].d);
      chk("wr_en", wr_en, exp_q[0].w);
    end else begin
      chk("idle_addr", d_addr, 0);
      chk("idle_data", d_data, 0);
      chk("idle_wr_en", wr_en, 0);
    end
    chk("st_ready", st_ready, st_q.size() < DEPTH);
    chk("empty", empty, st_q.size() == 0);
    chk("ld_hazard", ld_hazard, model_hazard(ld_addr));
    acc = st_valid && (st_q.size() < DEPTH) && (st_mask != 4'b0);
    ack = mem_ack && (exp_q.size() != 0);
    @(posedge clk);
    if (ack) begin
      t = exp_q.pop_front();
      if (t.last) void'(st_q.pop_front());
    end
    if (acc) add_store(st_addr, st_data, st_mask);
    #1;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("drain_done", exp_q.size(), 0);
    tick();
  endtask

  task automatic set_st(logic [31:0] a, logic [31:0] d,
                        logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] mk [4];
    mk[0] = 4'b0000;
    mk[1] = MASK_B;
    mk[2] = MASK_H;
    mk[3] = MASK_W;

    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_mask  = '0;
    mem_ack  = 1'b0;
    ld_addr  = '0;
    @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_d_addr", d_addr, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_hazard", ld_hazard, 0);
    chk("rst_empty", empty, 1);
    chk("rst_st_ready", st_ready, 1);
    rst = 1'b0;
    tick();

    // aligned word
    mem_ack = 1'b1;
    set_st(32'h100, 32'hDEADBEEF, MASK_W);
    tick();
    st_valid = 1'b0;
    chk("t1_req", mem_req, 1);
    chk("t1_addr", d_addr, 32'h100);
    chk("t1_data", d_data, 32'hDEADBEEF);
    chk("t1_wr_en", wr_en, 4'b1111);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_req_low", mem_req, 0);
    tick();

    // offset byte
    set_st(32'h103, 32'h000000AB, MASK_B);
    tick();
    st_valid = 1'b0;
    chk("t2_addr", d_addr, 32'h100);
    chk("t2_data", d_data, 32'hAB000000);
    chk("t2_wr_en", wr_en, 4'b1000);
    tick();
    chk("t2_empty", empty, 1);

    // word crossing
    set_st(32'h102, 32'h11223344, MASK_W);
    tick();
    st_valid = 1'b0;
    chk("t3_lo_addr", d_addr, 32'h100);
    chk("t3_lo_data", d_data, 32'h33440000);
    chk("t3_lo_wr_en", wr_en, 4'b1100);
    tick();
    chk("t3_hi_addr", d_addr, 32'h104);
    chk("t3_hi_data", d_data, 32'h00001122);
    chk("t3_hi_wr_en", wr_en, 4'b0011);
    chk("t3_not_popped", empty, 0);
    tick();
    chk("t3_empty", empty, 1);

    // fill with the memory stalled
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_st(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), MASK_W);
      tick();
    end
    chk("t4_full", st_ready, 0);
    set_st(32'h210, 32'hA4, MASK_W);
    tick();
    tick();
    chk("t4_stable_addr", d_addr, 32'h200);
    chk("t4_stable_data", d_data, 32'hA0);
    mem_ack = 1'b1;
    tick();
    chk("t4_ready_after_pop", st_ready, 1);
    tick();
    st_valid = 1'b0;
    drain();

    // load hazard on a crossing halfword
    mem_ack = 1'b0;
    set_st(32'h1FF, 32'h0000BEEF, MASK_H);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h1FC;
    #1 chk("t5_hz_lo", ld_hazard, 1);
    ld_addr = 32'h201;
    #1 chk("t5_hz_hi", ld_hazard, 1);
    ld_addr = 32'h204;
    #1 chk("t5_hz_none", ld_hazard, 0);
    ld_addr = 32'h1FC;
    mem_ack = 1'b1;
    tick();
    chk("t5_hz_in_hi", ld_hazard, 1);
    tick();
    chk("t5_hz_drained", ld_hazard, 0);

    // reset in the middle of a split write
    mem_ack = 1'b0;
    set_st(32'h102, 32'h55667788, MASK_W);
    tick();
    set_st(32'h306, 32'h99AABBCC, MASK_W);
    tick();
    set_st(32'h40A, 32'hDDEEFF00, MASK_W);
    tick();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t6_in_hi", d_addr, 32'h104);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_drop", mem_req, 0);
    chk("t6_wr_en_drop", wr_en, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ready", st_ready, 1);
    exp_q.delete();
    st_q.delete();
    tick();
    rst     = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      st_valid = ($urandom_range(0, 1) == 1);
      st_mask  = mk[$urandom_range(0, 3)];
      st_data  = $urandom;
      if ($urandom_range(0, 5) == 0)
        st_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        st_addr = 32'h100 + 32'($urandom_range(0, 23));
      if ($urandom_range(0, 5) == 0)
        ld_addr = 32'($urandom_range(0, 7));
      else
        ld_addr = 32'h0F8 + 32'($urandom_range(0, 39));
      mem_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
